// File: rtl/mont_exp_pkg.sv
// mont_exp_pkg: shared state encodings and width defaults
// for the modular exponentiation controller and multiplier.
package mont_exp_pkg;

  localparam int N_WIDTH_DEF  = 1024;
  localparam int E_WIDTH_DEF  = 32;
  localparam int L_WIDTH_DEF  = 6;
  localparam int MM_STEPS_DEF = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TO_MONT   = 3'd1,
    SQUARE    = 3'd2,
    MULTIPLY  = 3'd3,
    FROM_MONT = 3'd4,
    DONE      = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    MM_IDLE = 2'd0,
    MM_RUN  = 2'd1,
    MM_FIN  = 2'd2
  } mm_state_t;

  function automatic logic is_mm(input state_t s);
    return (s == TO_MONT) || (s == SQUARE) ||
           (s == MULTIPLY) || (s == FROM_MONT);
  endfunction

endpackage

// File: rtl/mont_exp_montgomery.sv
// montgomery: radix-2 Montgomery multiplier, a*b*2^-N mod m.
// Ports: clk, resetn, start, in_a/in_b/in_m, result, done.
module montgomery
  import mont_exp_pkg::*;
#(
  parameter int N_WIDTH = N_WIDTH_DEF,
  parameter int STEPS   = MM_STEPS_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [N_WIDTH-1:0] in_a,
  input  logic [N_WIDTH-1:0] in_b,
  input  logic [N_WIDTH-1:0] in_m,
  output logic [N_WIDTH:0]   result,
  output logic               done
);

  localparam int ITER = N_WIDTH / STEPS;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int TW   = N_WIDTH + 2;

  mm_state_t          state_q;
  mm_state_t          state_d;
  logic [N_WIDTH-1:0] a_q;
  logic [N_WIDTH-1:0] b_q;
  logic [N_WIDTH-1:0] m_q;
  logic [TW-1:0]      t_q;
  logic [TW-1:0]      t_d;
  logic [N_WIDTH-1:0] a_w;
  logic [N_WIDTH:0]   t_red;
  logic [CW-1:0]      cnt_q;
  logic               last;
  logic               ge;

  assign last = (cnt_q == CW'(ITER - 1));

  // STEPS radix-2 iterations per clock; the partial sum
  // stays below 2m so N+2 bits never overflow.
  always_comb begin
    t_d = t_q;
    a_w = a_q;
    for (int s = 0; s < STEPS; s++) begin
      if (a_w[0]) t_d = t_d + {2'b00, b_q};
      if (t_d[0]) t_d = t_d + {2'b00, m_q};
      t_d = {1'b0, t_d[TW-1:1]};
      a_w = a_w >> 1;
    end
  end

  // Final t < 2m: one conditional subtract gives < m.
  assign ge     = (t_q >= {2'b00, m_q});
  assign t_red  = t_q[N_WIDTH:0] - {1'b0, m_q};
  assign result = ge ? t_red : t_q[N_WIDTH:0];
  assign done   = (state_q == MM_FIN);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MM_IDLE: if (start) state_d = MM_RUN;
      MM_RUN:  if (last) state_d = MM_FIN;
      MM_FIN:  state_d = MM_IDLE;
      default: state_d = MM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= MM_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q   <= '0;
      b_q   <= '0;
      m_q   <= '0;
      t_q   <= '0;
      cnt_q <= '0;
    end else begin
      unique case (state_q)
        MM_IDLE: begin
          if (start) begin
            a_q   <= in_a;
            b_q   <= in_b;
            m_q   <= in_m;
            t_q   <= '0;
            cnt_q <= '0;
          end
        end
        MM_RUN: begin
          a_q   <= a_q >> STEPS;
          t_q   <= t_d;
          cnt_q <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mont_exp.sv
// mont_exp: x^e mod N by left-to-right square-and-multiply.
// Ports: operands in, result/busy/done out; drives montgomery.
module mont_exp
  import mont_exp_pkg::*;
#(
  parameter int N_WIDTH  = N_WIDTH_DEF,
  parameter int E_WIDTH  = E_WIDTH_DEF,
  parameter int L_WIDTH  = L_WIDTH_DEF,
  parameter int MM_STEPS = MM_STEPS_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [N_WIDTH-1:0] x_in,
  input  logic [N_WIDTH-1:0] n_in,
  input  logic [N_WIDTH-1:0] r_n_in,
  input  logic [N_WIDTH-1:0] r2_n_in,
  input  logic [E_WIDTH-1:0] e_in,
  input  logic [L_WIDTH-1:0] e_len_in,
  output logic [N_WIDTH-1:0] result,
  output logic               busy,
  output logic               done
);

  localparam logic [L_WIDTH-1:0] E_MAX = L_WIDTH'(E_WIDTH);
  localparam logic [N_WIDTH-1:0] ONE   = N_WIDTH'(1);

  state_t             state_q;
  state_t             state_d;
  logic               first_q;
  logic [N_WIDTH-1:0] x_q;
  logic [N_WIDTH-1:0] n_q;
  logic [N_WIDTH-1:0] r2_q;
  logic [N_WIDTH-1:0] a_q;
  logic [N_WIDTH-1:0] xt_q;
  logic [N_WIDTH-1:0] res_q;
  logic [E_WIDTH-1:0] e_q;
  logic [E_WIDTH-1:0] e_sh;
  logic [L_WIDTH-1:0] i_q;
  logic [L_WIDTH-1:0] len_eff;
  logic               zero_q;
  logic               e_bit;
  logic               i_zero;
  logic               accept;
  logic               mm_fire;
  logic               mm_start;
  logic               mm_done;
  logic [N_WIDTH-1:0] mm_a;
  logic [N_WIDTH-1:0] mm_b;
  logic [N_WIDTH:0]   mm_result;
  logic               unused_mm_msb;

  assign len_eff = (e_len_in > E_MAX) ? E_MAX : e_len_in;
  assign e_sh    = e_q >> i_q;
  assign e_bit   = e_sh[0];
  assign i_zero  = (i_q == '0);
  assign accept  = (state_q == IDLE) && start;
  assign mm_fire = is_mm(state_q) && mm_done;

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = res_q;

  // The multiplier always returns < N; its top bit is spare.
  assign unused_mm_msb = mm_result[N_WIDTH];

  always_comb begin
    state_d  = state_q;
    mm_start = 1'b0;
    mm_a     = '0;
    mm_b     = '0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = TO_MONT;
      end
      TO_MONT: begin
        mm_start = first_q;
        mm_a     = x_q;
        mm_b     = r2_q;
        if (mm_done)
          state_d = zero_q ? FROM_MONT : SQUARE;
      end
      SQUARE: begin
        mm_start = first_q;
        mm_a     = a_q;
        mm_b     = a_q;
        if (mm_done) begin
          if (e_bit)       state_d = MULTIPLY;
          else if (i_zero) state_d = FROM_MONT;
          else             state_d = SQUARE;
        end
      end
      MULTIPLY: begin
        mm_start = first_q;
        mm_a     = a_q;
        mm_b     = xt_q;
        if (mm_done)
          state_d = i_zero ? FROM_MONT : SQUARE;
      end
      FROM_MONT: begin
        mm_start = first_q;
        mm_a     = a_q;
        mm_b     = ONE;
        if (mm_done) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // first_q marks the opening cycle of every MM state,
  // including SQUARE re-entering itself.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      first_q <= 1'b0;
      x_q     <= '0;
      n_q     <= '0;
      r2_q    <= '0;
      a_q     <= '0;
      xt_q    <= '0;
      res_q   <= '0;
      e_q     <= '0;
      i_q     <= '0;
      zero_q  <= 1'b0;
    end else begin
      first_q <= accept || mm_fire;
      if (accept) begin
        x_q    <= x_in;
        n_q    <= n_in;
        r2_q   <= r2_n_in;
        e_q    <= e_in;
        a_q    <= r_n_in;
        zero_q <= (len_eff == '0);
        i_q    <= (len_eff == '0) ? '0
                : len_eff - L_WIDTH'(1);
      end
      if (mm_fire) begin
        unique case (state_q)
          TO_MONT: xt_q <= mm_result[N_WIDTH-1:0];
          SQUARE: begin
            a_q <= mm_result[N_WIDTH-1:0];
            if (!e_bit && !i_zero)
              i_q <= i_q - L_WIDTH'(1);
          end
          MULTIPLY: begin
            a_q <= mm_result[N_WIDTH-1:0];
            if (!i_zero)
              i_q <= i_q - L_WIDTH'(1);
          end
          FROM_MONT: res_q <= mm_result[N_WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  montgomery #(
    .N_WIDTH (N_WIDTH),
    .STEPS   (MM_STEPS)
  ) u_mm (
    .clk    (clk),
    .resetn (resetn),
    .start  (mm_start),
    .in_a   (mm_a),
    .in_b   (mm_b),
    .in_m   (n_q),
    .result (mm_result),
    .done   (mm_done)
  );

endmodule

// File: tb/tb_mont_exp.sv
// tb_mont_exp: scoreboard bench for mont_exp with the
// real multiplier; reference uses plain shift-add modmul.
module tb_mont_exp;

  localparam int NW    = 1024;
  localparam int EW    = 32;
  localparam int LW    = 6;
  localparam int STEPS = 8;
  localparam int LAT   = NW / STEPS + 1;
  localparam int PER   = LAT + 1;
  localparam int BUDGET = 12000;

  typedef struct {
    logic [NW-1:0] res;
    int            k;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [NW-1:0] x_in = '0;
  logic [NW-1:0] n_in = '0;
  logic [NW-1:0] r_n_in = '0;
  logic [NW-1:0] r2_n_in = '0;
  logic [EW-1:0] e_in = '0;
  logic [LW-1:0] e_len_in = '0;
  logic [NW-1:0] result;
  logic          busy;
  logic          done;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   mm_cnt = 0;
  int   done_cnt = 0;
  bit   active = 0;
  bit   post = 0;

  mont_exp #(
    .N_WIDTH  (NW),
    .E_WIDTH  (EW),
    .L_WIDTH  (LW),
    .MM_STEPS (STEPS)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .x_in     (x_in),
    .n_in     (n_in),
    .r_n_in   (r_n_in),
    .r2_n_in  (r2_n_in),
    .e_in     (e_in),
    .e_len_in (e_len_in),
    .result   (result),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [NW-1:0] got,
                     input logic [NW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (low 240 bits)",
               tag, got[239:0], want[239:0]);
    end
  endtask

  function automatic logic [NW-1:0] mulmod(
      input logic [NW-1:0] a, b, n);
    logic [NW:0]   r;
    logic [NW:0]   nn;
    logic [NW-1:0] bb;
    r  = '0;
    nn = {1'b0, n};
    bb = b;
    for (int j = 0; j < NW; j++) begin
      r = r << 1;
      if (r >= nn) r = r - nn;
      if (bb[NW-1]) begin
        r = r + {1'b0, a};
        if (r >= nn) r = r - nn;
      end
      bb = bb << 1;
    end
    return r[NW-1:0];
  endfunction

  function automatic logic [NW-1:0] rmod(
      input logic [NW-1:0] n);
    logic [NW:0] r;
    r = 1;
    for (int j = 0; j < NW; j++) begin
      r = r << 1;
      if (r >= {1'b0, n}) r = r - {1'b0, n};
    end
    return r[NW-1:0];
  endfunction

  function automatic int eff_len(input logic [LW-1:0] len);
    return (int'(len) > EW) ? EW : int'(len);
  endfunction

  function automatic int kfn(input logic [EW-1:0] e,
                             input logic [LW-1:0] len);
    int k;
    k = 2 + eff_len(len);
    for (int j = 0; j < eff_len(len); j++)
      if (((e >> j) & 1) != 0) k++;
    return k;
  endfunction

  function automatic logic [NW-1:0] ref_pow(
      input logic [NW-1:0] x, n,
      input logic [EW-1:0] e,
      input logic [LW-1:0] len);
    logic [NW-1:0] r;
    r = 1;
    for (int j = eff_len(len) - 1; j >= 0; j--) begin
      r = mulmod(r, r, n);
      if (((e >> j) & 1) != 0) r = mulmod(r, x, n);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [NW-1:0] x, n,
                      input logic [EW-1:0] e,
                      input logic [LW-1:0] len);
    logic [NW-1:0] rm;
    rm = rmod(n);
    x_in     = x;
    n_in     = n;
    r_n_in   = rm;
    r2_n_in  = mulmod(rm, rm, n);
    e_in     = e;
    e_len_in = len;
  endtask

  task automatic push(input logic [NW-1:0] res,
                      input int k);
    exp_t ex;
    ex.res = res;
    ex.k   = k;
    sb.push_back(ex);
  endtask

  task automatic pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || active) && n < BUDGET) begin
      tick();
      n++;
    end
    chk("idle_wait", NW'(n < BUDGET), NW'(1));
    if (n >= BUDGET) sb.delete();
  endtask

  task automatic run_ref(input logic [NW-1:0] x, n,
                         input logic [EW-1:0] e,
                         input logic [LW-1:0] len);
    load(x, n, e, len);
    push(ref_pow(x, n, e, len), kfn(e, len));
    pulse();
    wait_idle();
  endtask

  // Monitor: cycle 0 is the negedge where an accepted
  // start is seen; done must land at k*(L+1)+1.
  always @(negedge clk) begin
    exp_t ex;
    cyc++;
    if (!resetn) begin
      active = 0;
      post   = 0;
    end else begin
      if (post) begin
        chk("busy_fall", NW'(busy), NW'(0));
        post   = 0;
        active = 0;
      end
      if (!active && start) begin
        active = 1;
        t0     = cyc;
        mm_cnt = 0;
      end else if (active) begin
        if (cyc == t0 + 1)
          chk("busy_rise", NW'(busy), NW'(1));
        if (dut.mm_start) mm_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          chk("spurious_done", NW'(done), NW'(0));
        end else begin
          ex = sb.pop_front();
          chk("result", result, ex.res);
          chk("latency", NW'(cyc - t0),
              NW'(ex.k * PER + 1));
          chk("mm_count", NW'(mm_cnt), NW'(ex.k));
          post = 1;
        end
      end
    end
  end

  initial begin
    logic [NW-1:0] rn;
    logic [NW-1:0] rx;
    int            dc;
    int            n;

    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst_result", result, '0);
    chk("rst_busy", NW'(busy), NW'(0));
    chk("rst_done", NW'(done), NW'(0));
    tick();

    load(5, 143, 7, 3);
    push(47, 8);
    pulse();
    wait_idle();

    load(100, 143, 1, 1);
    push(100, 4);
    pulse();
    wait_idle();

    load(5, 143, 32'hFFFF_FFFF, 0);
    push(1, 2);
    pulse();
    wait_idle();

    load(5, 143, 32'h0, 32);
    push(1, 34);
    pulse();
    wait_idle();

    run_ref(123457, 1000003, 32'hA5C3_1F07, 40);

    // start pulses while busy must be ignored
    load(9, 143, 11, 4);
    push(ref_pow(9, 143, 11, 4), kfn(11, 4));
    pulse();
    repeat (50) tick();
    pulse();
    repeat (300) tick();
    pulse();
    wait_idle();

    // abort a run in its first SQUARE
    load(3, 143, 13, 4);
    pulse();
    repeat (200) tick();
    resetn = 1'b0;
    @(negedge clk);
    chk("abort_busy", NW'(busy), NW'(0));
    chk("abort_done", NW'(done), NW'(0));
    chk("abort_result", result, '0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    tick();
    run_ref(2, 143, 10, 4);

    // start held through DONE: second run right after
    load(6, 143, 5, 3);
    push(ref_pow(6, 143, 5, 3), kfn(5, 3));
    push(ref_pow(6, 143, 5, 3), kfn(5, 3));
    dc = done_cnt;
    start = 1'b1;
    n = 0;
    while (done_cnt == dc && n < BUDGET) begin
      tick();
      n++;
    end
    chk("b2b_first", NW'(n < BUDGET), NW'(1));
    tick();
    start = 1'b0;
    wait_idle();

    for (int r = 0; r < 2; r++) begin
      rn = '0;
      rx = '0;
      for (int w = 0; w < NW / 32; w++) begin
        rn = {rn[NW-33:0], 32'($urandom)};
        rx = {rx[NW-33:0], 32'($urandom)};
      end
      rn[NW-1] = 1'b1;
      rn[0]    = 1'b1;
      rx[NW-1] = 1'b0;
      run_ref(rx, rn, 32'($urandom), 32);
    end

    repeat (5) tick();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
